// File: rtl/pipelined_brick_sort.sv
// Odd-even transposition (brick) sorter: NUM_ELEMS registered compare-exchange stages with valid/ready flow.
// Optional macro SORT_PERM_EN adds per-element index tags and the dest_tperm output.
module pipelined_brick_sort #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 4,
  parameter int DESCENDING = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_tvalid,
  output logic                            src_tready,
  input  logic [DATA_WIDTH*NUM_ELEMS-1:0] src_tdata_raw,
  output logic                            dest_tvalid,
  input  logic                            dest_tready,
`ifdef SORT_PERM_EN
  output logic [NUM_ELEMS*$clog2(NUM_ELEMS)-1:0] dest_tperm,
`endif
  output logic [DATA_WIDTH*NUM_ELEMS-1:0] dest_tdata_raw
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = NUM_ELEMS;
  localparam int PW = $clog2(NUM_ELEMS);

  logic [N-1:0]   valid_reg;
  logic [N-1:0]   valid_in;
  logic [N:0]     load;
  logic [W-1:0]   stage_in  [N][N];
  logic [W-1:0]   data_next [N][N];
  logic [W-1:0]   data_reg  [N][N];
`ifdef SORT_PERM_EN
  logic [PW-1:0]  tag_in    [N][N];
  logic [PW-1:0]  tag_next  [N][N];
  logic [PW-1:0]  tag_reg   [N][N];
`endif

  // Strict comparison: equal elements never swap, which keeps the sort stable.
  function automatic logic out_of_order(input logic [W-1:0] lo, input logic [W-1:0] hi);
    if (DESCENDING != 0)
      return lo < hi;
    else
      return lo > hi;
  endfunction

  // A stage advances when it is empty or its successor is advancing too.
  always_comb begin
    load[N] = dest_tready;
    for (int k = N - 1; k >= 0; k--)
      load[k] = !valid_reg[k] || load[k+1];
  end

  assign valid_in = {valid_reg[N-2:0], src_tvalid};

  always_comb begin
    for (int j = 0; j < N; j++) begin
      stage_in[0][j] = src_tdata_raw[j*W +: W];
`ifdef SORT_PERM_EN
      tag_in[0][j] = PW'(j);
`endif
    end
    for (int k = 1; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        stage_in[k][j] = data_reg[k-1][j];
`ifdef SORT_PERM_EN
        tag_in[k][j] = tag_reg[k-1][j];
`endif
      end
    end

    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        data_next[k][j] = stage_in[k][j];
`ifdef SORT_PERM_EN
        tag_next[k][j] = tag_in[k][j];
`endif
      end
    end

    // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N - 1; j++) begin
        if ((j % 2) == (k % 2)) begin
          if (out_of_order(stage_in[k][j], stage_in[k][j+1])) begin
            data_next[k][j]   = stage_in[k][j+1];
            data_next[k][j+1] = stage_in[k][j];
`ifdef SORT_PERM_EN
            tag_next[k][j]    = tag_in[k][j+1];
            tag_next[k][j+1]  = tag_in[k][j];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          data_reg[k][j] <= '0;
`ifdef SORT_PERM_EN
          tag_reg[k][j]  <= '0;
`endif
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          valid_reg[k] <= valid_in[k];
          for (int j = 0; j < N; j++) begin
            data_reg[k][j] <= data_next[k][j];
`ifdef SORT_PERM_EN
            tag_reg[k][j]  <= tag_next[k][j];
`endif
          end
        end
      end
    end
  end

  assign src_tready  = load[0];
  assign dest_tvalid = valid_reg[N-1];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign dest_tdata_raw[gi*W +: W] = data_reg[N-1][gi];
`ifdef SORT_PERM_EN
      assign dest_tperm[gi*PW +: PW] = tag_reg[N-1][gi];
`endif
    end
  endgenerate

endmodule

// File: doc/pipelined_brick_sort.md
PIPELINED_BRICK_SORT -- requirements
Module: pipelined_brick_sort

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one unsigned element in bits.
REQ-002 Parameter NUM_ELEMS, default 4: elements per beat; legal range is >= 2.
REQ-003 Parameter DESCENDING, default 0: 0 sorts ascending from element 0 upward; 1 sorts descending.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 src_tvalid  input  1  input beat valid.
REQ-007 src_tready  output  1  block accepts the input beat.
REQ-008 src_tdata_raw  input  DATA_WIDTH*NUM_ELEMS  unsorted elements; element i is at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-009 dest_tvalid  output  1  output beat valid.
REQ-010 dest_tready  input  1  downstream accepts the output beat.
REQ-011 dest_tdata_raw  output  DATA_WIDTH*NUM_ELEMS  sorted elements, packed the same way as src_tdata_raw.
REQ-012 dest_tperm  output  NUM_ELEMS*clog2(NUM_ELEMS)  original input index of each output element; this port exists only under SORT_PERM_EN.

Function
REQ-013 The block SHALL be an odd-even transposition network of NUM_ELEMS registered stages, numbered 0 to NUM_ELEMS-1.
REQ-014 Even stage k SHALL compare pairs (0,1), (2,3), ...; odd stage k SHALL compare pairs (1,2), (3,4), ...; an unpaired edge element SHALL pass through unchanged.
REQ-015 Compare-exchange, ascending: swap only when lower-index element > higher-index element (strict, unsigned). Descending: swap only when lower-index element < higher-index element. Ties are never swapped, so the sort is stable.
REQ-016 Each stage SHALL hold one valid bit plus a data register; stage 0 loads from src_tdata_raw.
REQ-017 Stage k SHALL load when (stage k empty) or (stage k+1 able to load); the last stage's downstream condition is dest_tready.
REQ-018 src_tready SHALL equal stage 0's load condition; a beat transfers when src_tvalid and src_tready are both high.
REQ-019 dest_tvalid and dest_tdata_raw SHALL be driven directly from the last stage's registers, with no combinational path from src to dest.
REQ-020 Latency: with dest_tready held high, a beat accepted at edge N SHALL appear at dest with dest_tvalid high after edge N+NUM_ELEMS-1, i.e. NUM_ELEMS register stages.
REQ-021 Throughput SHALL be one beat per cycle while dest_tready is high.
REQ-022 Backpressure: stages SHALL fill (bubbles collapse) until all NUM_ELEMS stages are valid, and only then SHALL src_tready deassert.
REQ-023 While dest_tvalid is high and dest_tready is low, dest_tdata_raw SHALL be held stable.
REQ-024 Beat order SHALL be preserved; beats SHALL never be dropped or duplicated.
REQ-025 Simultaneous accept at stage 0 and emit at the last stage in a full pipeline SHALL be lossless.

Reset
REQ-026 On rst, all stage valid bits SHALL clear asynchronously, and dest_tvalid SHALL be 0 while rst is high.
REQ-027 On rst, all data and permutation registers SHALL clear to 0, so dest_tdata_raw = 0 and dest_tperm = 0.
REQ-028 src_tready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-operation SHALL discard all in-flight beats, and no beat accepted before reset SHALL ever appear at dest.

Configuration
REQ-030 Macro SORT_PERM_EN defined: each stage carries a clog2(NUM_ELEMS)-bit tag per element, initialised to i for element i, and swapped together with its element; the final tags SHALL drive dest_tperm.
REQ-031 Macro SORT_PERM_EN undefined: the dest_tperm port and all tag registers SHALL be absent, and data behaviour SHALL be identical to the defined case.

Verification (NUM_ELEMS=4, DATA_WIDTH=8)
REQ-032 Ascending basic: input elements e0..e3 = 0x40, 0x10, 0x30, 0x20 -> output 0x10, 0x20, 0x30, 0x40 exactly 4 edges after accept; with SORT_PERM_EN, dest_tperm = 1, 3, 2, 0.
REQ-033 DESCENDING=1: same input -> output 0x40, 0x30, 0x20, 0x10, and dest_tperm = 0, 2, 3, 1.
REQ-034 Stability: input 0x05, 0x05, 0x01, 0x05 -> output 0x01, 0x05, 0x05, 0x05, and dest_tperm = 2, 0, 1, 3.
REQ-035 Backpressure: hold dest_tready low and stream beats -> exactly 4 beats accepted, then src_tready = 0 and dest_tdata_raw stable; release dest_tready -> all beats emerge in order, each sorted.
REQ-036 Reset mid-stream: assert rst with 3 stages valid -> dest_tvalid = 0 immediately; after release, no pre-reset beat appears at dest.
REQ-037 Random stream with random dest_tready -> every accepted beat is output once, in order, monotonic, and a permutation of its input.
